// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the bus-CPU control path: opcodes, control-word bit
// positions, T-state encoding and widths.
package cpu_ctrl_pkg;

  localparam int CTRL_W = 16;
  localparam int OPC_W  = 4;
  localparam int TS_W   = 3;

  localparam logic [OPC_W-1:0] OP_NOP = 4'd0;
  localparam logic [OPC_W-1:0] OP_LDA = 4'd1;
  localparam logic [OPC_W-1:0] OP_ADD = 4'd2;
  localparam logic [OPC_W-1:0] OP_SUB = 4'd3;
  localparam logic [OPC_W-1:0] OP_STA = 4'd4;
  localparam logic [OPC_W-1:0] OP_LDI = 4'd5;
  localparam logic [OPC_W-1:0] OP_JMP = 4'd6;
  localparam logic [OPC_W-1:0] OP_JC  = 4'd7;
  localparam logic [OPC_W-1:0] OP_JZ  = 4'd8;
  localparam logic [OPC_W-1:0] OP_OUT = 4'd14;
  localparam logic [OPC_W-1:0] OP_HLT = 4'd15;

  // Bit positions inside the control word; bit 15 is reserved and never driven.
  localparam int PC_INC   = 0;
  localparam int PC_OUT   = 1;
  localparam int PC_LOAD  = 2;
  localparam int MAR_IN   = 3;
  localparam int RAM_OUT  = 4;
  localparam int RAM_IN   = 5;
  localparam int IR_IN    = 6;
  localparam int IR_OUT   = 7;
  localparam int A_IN     = 8;
  localparam int A_OUT    = 9;
  localparam int B_IN     = 10;
  localparam int ALU_OUT  = 11;
  localparam int ALU_SUB  = 12;
  localparam int OUT_IN   = 13;
  localparam int FLAGS_IN = 14;

  localparam logic [TS_W-1:0] T0 = 3'd0;
  localparam logic [TS_W-1:0] T1 = 3'd1;
  localparam logic [TS_W-1:0] T2 = 3'd2;
  localparam logic [TS_W-1:0] T3 = 3'd3;
  localparam logic [TS_W-1:0] T4 = 3'd4;

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode: maps (opcode, T-state, flags) to one control word
// and flags the final step of the instruction.
module microcode_rom
  import cpu_ctrl_pkg::*;
#(
  parameter int CW_W = CTRL_W
) (
  input  logic [OPC_W-1:0] opcode,
  input  logic [TS_W-1:0]  tstate,
  input  logic             carry,
  input  logic             zero,
  output logic [CW_W-1:0]  ctrl_word,
  output logic             last_step
);

  logic [CTRL_W-1:0] word;
  logic              mem_op;

  assign mem_op = (opcode == OP_LDA) || (opcode == OP_ADD) ||
                  (opcode == OP_SUB) || (opcode == OP_STA);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    word      = '0;
    last_step = 1'b0;
    case (tstate)
      T0: begin
        word[PC_OUT] = 1'b1;
        word[MAR_IN] = 1'b1;
      end
      T1: begin
        word[RAM_OUT] = 1'b1;
        word[IR_IN]   = 1'b1;
        word[PC_INC]  = 1'b1;
      end
      T2: begin
        last_step = !mem_op;
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            word[IR_OUT] = 1'b1;
            word[MAR_IN] = 1'b1;
          end
          OP_LDI: begin
            word[IR_OUT] = 1'b1;
            word[A_IN]   = 1'b1;
          end
          OP_JMP: begin
            word[IR_OUT]  = 1'b1;
            word[PC_LOAD] = 1'b1;
          end
          OP_JC: begin
            word[IR_OUT]  = carry;
            word[PC_LOAD] = carry;
          end
          OP_JZ: begin
            word[IR_OUT]  = zero;
            word[PC_LOAD] = zero;
          end
          OP_OUT: begin
            word[A_OUT]  = 1'b1;
            word[OUT_IN] = 1'b1;
          end
          OP_NOP, OP_HLT: word = '0;
          default:        word = '0;
        endcase
      end
      T3: begin
        last_step = (opcode != OP_ADD) && (opcode != OP_SUB);
        case (opcode)
          OP_LDA: begin
            word[RAM_OUT] = 1'b1;
            word[A_IN]    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            word[RAM_OUT] = 1'b1;
            word[B_IN]    = 1'b1;
          end
          OP_STA: begin
            word[A_OUT]  = 1'b1;
            word[RAM_IN] = 1'b1;
          end
          default: word = '0;
        endcase
      end
      T4: begin
        last_step = 1'b1;
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          word[ALU_OUT]  = 1'b1;
          word[A_IN]     = 1'b1;
          word[FLAGS_IN] = 1'b1;
          word[ALU_SUB]  = (opcode == OP_SUB);
        end
      end
      // Unreachable encodings fall back to fetch so the counter cannot stick.
      default: last_step = 1'b1;
    endcase
  end

  assign ctrl_word = CW_W'(word);

endmodule

// File: rtl/control_sequencer.sv
// T-state sequencer for the 8-bit bus CPU: owns the step counter, the HALT
// state and run gating, and issues the microcode word for the current step.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int CW_W = CTRL_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic [3:0]      opcode,
  input  logic            carry,
  input  logic            zero,
  output logic [CW_W-1:0] ctrl,
  output logic [2:0]      tstate,
  output logic            halted
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [0:0]      state;
  logic [TS_W-1:0] tstate_q;
  logic [CW_W-1:0] rom_word;
  logic            last_step;
  logic            advance;

  microcode_rom #(.CW_W(CW_W)) u_rom (
    .opcode    (opcode),
    .tstate    (tstate_q),
    .carry     (carry),
    .zero      (zero),
    .ctrl_word (rom_word),
    .last_step (last_step)
  );

  assign advance = (state == ST_RUN) && run;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_RUN;
      tstate_q <= T0;
    end else if (advance) begin
      // HLT parks the counter on T2; only reset brings it back.
      if (tstate_q == T2 && opcode == OP_HLT) begin
        state <= ST_HALT;
      end else if (last_step) begin
        tstate_q <= T0;
      end else begin
        tstate_q <= tstate_q + 3'd1;
      end
    end
  end

  // Reset gates ctrl directly so it is zero while reset is low even if run=1.
  assign ctrl   = (reset && advance) ? rom_word : '0;
  assign tstate = tstate_q;
  assign halted = (state == ST_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed scenarios plus a
// randomized run compared against an instruction-level reference model.
module tb_control_sequencer;

  logic        clk;
  logic        reset;
  logic        run;
  logic [3:0]  opcode;
  logic        carry;
  logic        zero;
  logic [15:0] ctrl;
  logic [2:0]  tstate;
  logic        halted;

  int n_checks = 0;
  int n_fail   = 0;

  control_sequencer #(.CW_W(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .run    (run),
    .opcode (opcode),
    .carry  (carry),
    .zero   (zero),
    .ctrl   (ctrl),
    .tstate (tstate),
    .halted (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word the datapath should see at a given step of an instruction.
  function automatic logic [15:0] ref_word(int op, int step, bit c, bit z);
    if (step == 0) return 16'h000A;
    if (step == 1) return 16'h0051;
    case (op)
      1:  return (step == 2) ? 16'h0088 : 16'h0110;
      2:  return (step == 2) ? 16'h0088 : (step == 3) ? 16'h0410 : 16'h4900;
      3:  return (step == 2) ? 16'h0088 : (step == 3) ? 16'h0410 : 16'h5900;
      4:  return (step == 2) ? 16'h0088 : 16'h0220;
      5:  return 16'h0180;
      6:  return 16'h0084;
      7:  return c ? 16'h0084 : 16'h0000;
      8:  return z ? 16'h0084 : 16'h0000;
      14: return 16'h2200;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic int ref_len(int op);
    if (op == 2 || op == 3) return 5;
    if (op == 1 || op == 4) return 4;
    return 3;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT at T0 with reset released, mid-cycle.
  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    #3;
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; opcode = 4'd0; carry = 1'b0; zero = 1'b0;
    #1;
    reset = 1'b0;
    #2;
    n_checks++;
    if (tstate !== 3'd0 || halted !== 1'b0 || ctrl !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_async: tstate=%0d halted=%b ctrl=%h, want 0/0/0000", tstate, halted, ctrl);
    end
    run = 1'b1;
    #1;
    n_checks++;
    if (ctrl !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_run_high: ctrl=%h, want 0000", ctrl);
    end
    @(negedge clk);
    reset = 1'b1;
    opcode = 4'd5;
    #1;
    n_checks++;
    if (ctrl !== 16'h000A || tstate !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_release: ctrl=%h tstate=%0d, want 000A/0", ctrl, tstate);
    end
    tick();
    n_checks++;
    if (ctrl !== 16'h0051 || tstate !== 3'd1) begin
      n_fail++;
      $display("FAIL reset_first_edge: ctrl=%h tstate=%0d, want 0051/1", ctrl, tstate);
    end
  endtask

  // Back-to-back instructions, including both outcomes of JC/JZ.
  task automatic test_instructions();
    int ops[13] = '{5, 2, 3, 7, 7, 8, 8, 1, 4, 6, 14, 0, 11};
    bit cs[13]  = '{0, 1, 0, 0, 1, 1, 0, 0, 1, 0, 1, 0, 1};
    bit zs[13]  = '{1, 0, 1, 1, 0, 0, 1, 1, 0, 1, 0, 1, 0};
    logic [15:0] exp_w;
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 13; i++) begin
      opcode = 4'(ops[i]);
      carry  = cs[i];
      zero   = zs[i];
      for (int s = 0; s < ref_len(ops[i]); s++) begin
        exp_w = ref_word(ops[i], s, cs[i], zs[i]);
        #1;
        n_checks++;
        if (ctrl !== exp_w || tstate !== 3'(s) || halted !== 1'b0) begin
          n_fail++;
          $display("FAIL instr op=%0d c=%0d z=%0d step %0d: ctrl=%h tstate=%0d halted=%b, want %h/%0d/0",
                   ops[i], cs[i], zs[i], s, ctrl, tstate, halted, exp_w, s);
        end
        tick();
      end
    end
    n_checks++;
    if (tstate !== 3'd0) begin
      n_fail++;
      $display("FAIL instr_wrap: tstate=%0d, want 0", tstate);
    end
  endtask

  task automatic test_halt();
    do_reset();
    run = 1'b1; opcode = 4'd15;
    for (int s = 0; s < 3; s++) begin
      #1;
      n_checks++;
      if (ctrl !== ref_word(15, s, 0, 0) || halted !== 1'b0) begin
        n_fail++;
        $display("FAIL halt_fetch step %0d: ctrl=%h halted=%b, want %h/0", s, ctrl, halted, ref_word(15, s, 0, 0));
      end
      tick();
    end
    for (int k = 0; k < 20; k++) begin
      run = 1'($urandom % 2);
      #1;
      n_checks++;
      if (halted !== 1'b1 || ctrl !== 16'h0000 || tstate !== 3'd2) begin
        n_fail++;
        $display("FAIL halt_hold cycle %0d: halted=%b ctrl=%h tstate=%0d, want 1/0000/2", k, halted, ctrl, tstate);
      end
      tick();
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (halted !== 1'b0 || tstate !== 3'd0 || ctrl !== 16'h0000) begin
      n_fail++;
      $display("FAIL halt_reset: halted=%b tstate=%0d ctrl=%h, want 0/0/0000", halted, tstate, ctrl);
    end
    #2;
    reset = 1'b1;
    run = 1'b1;
    #1;
    n_checks++;
    if (ctrl !== 16'h000A) begin
      n_fail++;
      $display("FAIL halt_restart: ctrl=%h, want 000A", ctrl);
    end
  endtask

  task automatic test_run_stall();
    do_reset();
    run = 1'b1; opcode = 4'd2;
    for (int s = 0; s < 3; s++) begin
      #1;
      n_checks++;
      if (ctrl !== ref_word(2, s, 0, 0)) begin
        n_fail++;
        $display("FAIL stall_pre step %0d: ctrl=%h, want %h", s, ctrl, ref_word(2, s, 0, 0));
      end
      tick();
    end
    run = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++;
      if (ctrl !== 16'h0000 || tstate !== 3'd3) begin
        n_fail++;
        $display("FAIL stall_hold cycle %0d: ctrl=%h tstate=%0d, want 0000/3", k, ctrl, tstate);
      end
      tick();
    end
    run = 1'b1;
    #1;
    n_checks++;
    if (ctrl !== 16'h0410 || tstate !== 3'd3) begin
      n_fail++;
      $display("FAIL stall_resume_t3: ctrl=%h tstate=%0d, want 0410/3", ctrl, tstate);
    end
    tick();
    n_checks++;
    if (ctrl !== 16'h4900 || tstate !== 3'd4) begin
      n_fail++;
      $display("FAIL stall_resume_t4: ctrl=%h tstate=%0d, want 4900/4", ctrl, tstate);
    end
    tick();
    n_checks++;
    if (tstate !== 3'd0) begin
      n_fail++;
      $display("FAIL stall_wrap: tstate=%0d, want 0", tstate);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    run = 1'b1; opcode = 4'd4;
    for (int s = 0; s < 3; s++) begin
      #1;
      n_checks++;
      if (ctrl !== ref_word(4, s, 0, 0)) begin
        n_fail++;
        $display("FAIL sta_pre step %0d: ctrl=%h, want %h", s, ctrl, ref_word(4, s, 0, 0));
      end
      tick();
    end
    #1;
    n_checks++;
    if (ctrl !== 16'h0220 || tstate !== 3'd3) begin
      n_fail++;
      $display("FAIL sta_t3: ctrl=%h tstate=%0d, want 0220/3", ctrl, tstate);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (ctrl !== 16'h0000 || tstate !== 3'd0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL sta_abort: ctrl=%h tstate=%0d halted=%b, want 0000/0/0", ctrl, tstate, halted);
    end
    tick();
    n_checks++;
    if (ctrl[5] !== 1'b0 || tstate !== 3'd0) begin
      n_fail++;
      $display("FAIL sta_reset_hold: ctrl=%h tstate=%0d, want ram_in=0/0", ctrl, tstate);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (ctrl !== 16'h000A || tstate !== 3'd0) begin
      n_fail++;
      $display("FAIL sta_restart_t0: ctrl=%h tstate=%0d, want 000A/0", ctrl, tstate);
    end
    tick();
    n_checks++;
    if (ctrl !== 16'h0051 || tstate !== 3'd1) begin
      n_fail++;
      $display("FAIL sta_restart_t1: ctrl=%h tstate=%0d, want 0051/1", ctrl, tstate);
    end
  endtask

  // Random run/opcode/flag traffic against an instruction-step model.
  task automatic test_random();
    int step = 0;
    int cur_op = 0;
    logic [15:0] exp_w;
    do_reset();
    for (int k = 0; k < 600; k++) begin
      run   = ($urandom % 4) != 0;
      carry = 1'($urandom);
      zero  = 1'($urandom);
      opcode = (step < 2) ? 4'($urandom) : 4'(cur_op);
      exp_w = run ? ref_word(cur_op, step, carry, zero) : 16'h0000;
      #1;
      n_checks++;
      if (ctrl !== exp_w || tstate !== 3'(step) || halted !== 1'b0) begin
        n_fail++;
        $display("FAIL random cycle %0d op=%0d run=%b c=%b z=%b: ctrl=%h tstate=%0d halted=%b, want %h/%0d/0",
                 k, cur_op, run, carry, zero, ctrl, tstate, halted, exp_w, step);
      end
      if (run) begin
        if (step >= 2 && step + 1 == ref_len(cur_op)) begin
          step = 0;
        end else begin
          step++;
          if (step == 2) cur_op = int'($urandom_range(0, 14));
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_instructions();
    test_halt();
    test_run_stall();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Microcode sequencer for the 8-bit bus CPU.
- Steps a T-state counter through fetch and execute.
- Decodes the 4-bit opcode from the instruction register, plus the carry and zero flags, into one 16-bit control word per cycle.
- Sits directly upstream of the datapath (PC, MAR, RAM, IR, A, B, ALU, OUT). Those registers latch on the clock edge that ends the cycle in which their control bit is high.

## Interface
Parameters:
- `CW_W`, default 16, control-word width. Fixed bit map, see Operation.

Ports:
- `clk`  in  1  system clock; every state change happens on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `run`  in  1  1 = advance the sequence; 0 = freeze the state and force `ctrl` to 0.
- `opcode`  in  4  IR[7:4]; stable from T2 onward.
- `carry`  in  1  carry flag from the flags register.
- `zero`  in  1  zero flag from the flags register.
- `ctrl`  out  16  control word for the current cycle.
- `tstate`  out  3  current micro-step, 0..4.
- `halted`  out  1  high after HLT executes; cleared only by reset.

## Operation
- `ctrl` bit map:
  - 0 pc_inc, 1 pc_out, 2 pc_load, 3 mar_in
  - 4 ram_out, 5 ram_in, 6 ir_in, 7 ir_out
  - 8 a_in, 9 a_out, 10 b_in, 11 alu_out
  - 12 alu_sub, 13 out_in, 14 flags_in, 15 reserved (always 0)
- Fetch (every instruction):
  - T0 = pc_out|mar_in
  - T1 = ram_out|ir_in|pc_inc
- Execute:
  - LDA (1): T2 ir_out|mar_in; T3 ram_out|a_in.
  - ADD (2): T2 ir_out|mar_in; T3 ram_out|b_in; T4 alu_out|a_in|flags_in.
  - SUB (3): same as ADD, with alu_sub added in T4.
  - STA (4): T2 ir_out|mar_in; T3 a_out|ram_in.
  - LDI (5): T2 ir_out|a_in.
  - JMP (6): T2 ir_out|pc_load.
  - JC (7): T2 ir_out|pc_load if `carry`=1, otherwise 0.
  - JZ (8): T2 ir_out|pc_load if `zero`=1, otherwise 0.
  - OUT (14): T2 a_out|out_in.
  - HLT (15): T2 = 0, then go to HALT.
  - NOP (0) and undefined opcodes (9-13): T2 = 0.
- Variable-length sequence: after an instruction's last step the counter returns to T0.
- Cycles per instruction:
  - ADD, SUB: 5
  - LDA, STA: 4
  - all other opcodes: 3
- States: RUN(tstate), HALT.
  - RUN, `run`=1: advance to the next step, or to T0 after the last step.
  - RUN, `run`=0: hold the state; `ctrl`=0.
  - HLT at T2 → HALT at the next edge.
  - HALT: `halted`=1, `ctrl`=0, `tstate` holds 2, `run` is ignored.
  - Only reset leaves HALT.
- `ctrl` is a combinational decode of the registered state, `run`, `opcode` and flags.
- Flags are sampled only in T2 of JC/JZ. `opcode` is ignored in T0/T1.

## Timing
- While `reset`=0, without waiting for a clock: `tstate`=0, `halted`=0, `ctrl`=0.
- After `reset` deasserts with `run`=1: `ctrl`=0x000A, and the first edge moves to T1.
- Reset mid-instruction aborts the instruction. No partial step is repeated.
- A step's `ctrl` is valid for the whole cycle; the datapath captures on the closing edge.
- `run` falling mid-instruction freezes at the current step. When `run` rises, that step's `ctrl` is reissued in full.
- T4 wraps to T0. No `tstate` value above 4 is reachable in RUN.

## Structure
- Package `cpu_ctrl_pkg`:
  - opcode localparams (NOP..HLT)
  - ctrl bit-index localparams
  - T-state encoding
  - width constants
- Sub-module `microcode_rom`:
  - purely combinational
  - inputs: {`opcode`, `tstate`, `carry`, `zero`}
  - outputs: {ctrl word, last_step}
- The sequencer owns the counter, the HALT state, `run` gating and reset.

## Test plan
- Reset, `run`=1, `opcode`=LDI → `tstate` 0,1,2,0; `ctrl` 0x000A, 0x0051, 0x0180, 0x000A.
- `opcode`=ADD → T2..T4 `ctrl` 0x0088, 0x0410, 0x4900, then T0. With SUB, T4 = 0x5900.
- JC with `carry`=0 → T2 `ctrl`=0x0000, then T0. With `carry`=1 → T2 0x0084. Repeat for JZ using `zero`.
- HLT → after T2, `halted`=1 and `ctrl`=0 for 20 cycles with `run` toggling. A `reset` pulse → `halted`=0 and `tstate`=0.
- ADD, drop `run` at T3 for 5 cycles → `ctrl`=0 and `tstate`=3 held. Raise `run` → 0x0410, then 0x4900.
- Assert `reset` asynchronously mid-T3 of STA, between clock edges → `ctrl`=0 and `tstate`=0 before the next edge. `ram_in` is never seen high.
